// File: rtl/intra16_resgen.sv
// 16x16 luma intra residual generator: captures neighbours, derives the DC predictor,
// then streams V/H/DC residual rows. Optional saturation: define INTRA16_RES_CLIP_EN.
module intra16_resgen #(
  parameter int PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [16*PIX_W-1:0]      top_pix,
  input  logic [16*PIX_W-1:0]      left_pix,
  input  logic                     top_avail,
  input  logic                     left_avail,
  input  logic                     org_valid,
  output logic                     org_ready,
  input  logic [16*PIX_W-1:0]      org_row,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [16*(PIX_W+1)-1:0]  vres_row,
  output logic [16*(PIX_W+1)-1:0]  hres_row,
  output logic [16*(PIX_W+1)-1:0]  dcres_row,
  output logic [3:0]               res_rownum,
  output logic                     res_last,
  output logic                     v_ok,
  output logic                     h_ok,
  output logic [PIX_W-1:0]         dc_val,
  output logic                     busy,
  output logic                     done
);

  localparam int RES_W = PIX_W + 1;
  localparam int SUM_W = PIX_W + 4;
  localparam int ALL_W = PIX_W + 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUM    = 3'd1,
    DIV    = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t                 state_r, state_nx;
  logic [16*PIX_W-1:0]    top_r, left_r;
  logic                   v_ok_r, h_ok_r;
  logic [SUM_W-1:0]       sum_t_r, sum_l_r;
  logic [SUM_W-1:0]       sum_t_s, sum_l_s;
  logic [ALL_W-1:0]       sum_all_s;
  logic [PIX_W-1:0]       dc_r, dc_calc_s;
  logic [3:0]             row_cnt_r;
  logic                   res_valid_r, res_last_r, done_r, busy_r;
  logic [3:0]             res_rownum_r;
  logic [16*RES_W-1:0]    vres_r, hres_r, dcres_r;
  logic [16*RES_W-1:0]    vres_s, hres_s, dcres_s;
  logic [PIX_W-1:0]       left_sel_s;
  logic                   org_ready_s, accept_s, consume_s;

  // Zero-extended difference, optionally saturated to the signed PIX_W range.
  function automatic logic [RES_W-1:0] resid(input logic [PIX_W-1:0] o,
                                             input logic [PIX_W-1:0] p);
    logic [RES_W-1:0] d;
    logic [RES_W-1:0] q;
    d = {1'b0, o} - {1'b0, p};
`ifdef INTRA16_RES_CLIP_EN
    if (!d[RES_W-1] && d[PIX_W-1]) begin
      q = {2'b00, {(PIX_W-1){1'b1}}};
    end else if (d[RES_W-1] && !d[PIX_W-1]) begin
      q = {2'b11, {(PIX_W-1){1'b0}}};
    end else begin
      q = d;
    end
`else
    q = d;
`endif
    return q;
  endfunction

  // Handshake qualifiers.
  always_comb begin
    org_ready_s = (state_r == STREAM) && (!res_valid_r || res_ready);
    accept_s    = org_valid && org_ready_s;
    consume_s   = res_valid_r && res_ready;
  end

  // Neighbour sums for the DC predictor.
  always_comb begin
    sum_t_s = {SUM_W{1'b0}};
    sum_l_s = {SUM_W{1'b0}};
    for (int c = 0; c < 16; c++) begin
      sum_t_s = sum_t_s + {4'b0000, top_r[c*PIX_W +: PIX_W]};
      sum_l_s = sum_l_s + {4'b0000, left_r[c*PIX_W +: PIX_W]};
    end
  end

  // Rounded DC predictor selected by neighbour availability.
  always_comb begin
    sum_all_s = {1'b0, sum_t_r} + {1'b0, sum_l_r} + {{(ALL_W-5){1'b0}}, 5'd16};
    dc_calc_s = {1'b1, {(PIX_W-1){1'b0}}};
    case ({v_ok_r, h_ok_r})
      2'b11:   dc_calc_s = PIX_W'(sum_all_s >> 3'd5);
      2'b10:   dc_calc_s = PIX_W'((sum_t_r + {{(SUM_W-4){1'b0}}, 4'd8}) >> 3'd4);
      2'b01:   dc_calc_s = PIX_W'((sum_l_r + {{(SUM_W-4){1'b0}}, 4'd8}) >> 3'd4);
      2'b00:   dc_calc_s = {1'b1, {(PIX_W-1){1'b0}}};
      default: dc_calc_s = {1'b1, {(PIX_W-1){1'b0}}};
    endcase
  end

  // Residuals for the row being offered; the left predictor is row-dependent.
  always_comb begin
    vres_s     = {(16*RES_W){1'b0}};
    hres_s     = {(16*RES_W){1'b0}};
    dcres_s    = {(16*RES_W){1'b0}};
    left_sel_s = left_r[row_cnt_r*PIX_W +: PIX_W];
    for (int c = 0; c < 16; c++) begin
      vres_s[c*RES_W +: RES_W]  = resid(org_row[c*PIX_W +: PIX_W], top_r[c*PIX_W +: PIX_W]);
      hres_s[c*RES_W +: RES_W]  = resid(org_row[c*PIX_W +: PIX_W], left_sel_s);
      dcres_s[c*RES_W +: RES_W] = resid(org_row[c*PIX_W +: PIX_W], dc_r);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = SUM;
        end else begin
          state_nx = IDLE;
        end
      end
      SUM:    state_nx = DIV;
      DIV:    state_nx = STREAM;
      STREAM: begin
        if (accept_s && (row_cnt_r == 4'd15)) begin
          state_nx = DRAIN;
        end else begin
          state_nx = STREAM;
        end
      end
      DRAIN: begin
        if (consume_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register with busy/done flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx != IDLE);
      done_r  <= (state_r == DRAIN) && consume_s;
    end
  end

  // Neighbour capture, sums and DC predictor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_r   <= {(16*PIX_W){1'b0}};
      left_r  <= {(16*PIX_W){1'b0}};
      v_ok_r  <= 1'b0;
      h_ok_r  <= 1'b0;
      sum_t_r <= {SUM_W{1'b0}};
      sum_l_r <= {SUM_W{1'b0}};
      dc_r    <= {PIX_W{1'b0}};
    end else begin
      if ((state_r == IDLE) && start) begin
        top_r  <= top_pix;
        left_r <= left_pix;
        v_ok_r <= top_avail;
        h_ok_r <= left_avail;
      end
      if (state_r == SUM) begin
        sum_t_r <= sum_t_s;
        sum_l_r <= sum_l_s;
      end
      if (state_r == DIV) begin
        dc_r <= dc_calc_s;
      end
    end
  end

  // Residual output stage: load on accept, hold under backpressure, drop when drained.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_cnt_r    <= 4'd0;
      res_valid_r  <= 1'b0;
      res_last_r   <= 1'b0;
      res_rownum_r <= 4'd0;
      vres_r       <= {(16*RES_W){1'b0}};
      hres_r       <= {(16*RES_W){1'b0}};
      dcres_r      <= {(16*RES_W){1'b0}};
    end else begin
      if ((state_r == IDLE) && start) begin
        row_cnt_r <= 4'd0;
      end else if (accept_s) begin
        row_cnt_r <= row_cnt_r + 4'd1;
      end
      if (accept_s) begin
        res_valid_r  <= 1'b1;
        res_rownum_r <= row_cnt_r;
        res_last_r   <= (row_cnt_r == 4'd15);
        vres_r       <= vres_s;
        hres_r       <= hres_s;
        dcres_r      <= dcres_s;
      end else if (consume_s) begin
        res_valid_r <= 1'b0;
        res_last_r  <= 1'b0;
      end
    end
  end

  assign org_ready  = org_ready_s;
  assign res_valid  = res_valid_r;
  assign vres_row   = vres_r;
  assign hres_row   = hres_r;
  assign dcres_row  = dcres_r;
  assign res_rownum = res_rownum_r;
  assign res_last   = res_last_r;
  assign v_ok       = v_ok_r;
  assign h_ok       = h_ok_r;
  assign dc_val     = dc_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_intra16_resgen.sv
// Scoreboard bench for intra16_resgen: expected residual rows are queued on each
// accepted org row and checked when the DUT presents them.
module tb_intra16_resgen;

  localparam int PW = 8;
  localparam int RW = 9;

  logic             clk;
  logic             reset;
  logic             start;
  logic [16*PW-1:0] top_pix, left_pix, org_row;
  logic             top_avail, left_avail, org_valid, res_ready;
  logic             org_ready, res_valid, res_last, v_ok, h_ok, busy, done;
  logic [16*RW-1:0] vres_row, hres_row, dcres_row;
  logic [3:0]       res_rownum;
  logic [PW-1:0]    dc_val;

  typedef struct {
    logic [16*RW-1:0] v;
    logic [16*RW-1:0] h;
    logic [16*RW-1:0] d;
    logic [3:0]       num;
    logic             last;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_top[16];
  int   m_left[16];
  int   org_tb[16][16];
  int   m_dc;
  bit   m_v, m_h;

  intra16_resgen #(.PIX_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .top_pix(top_pix), .left_pix(left_pix),
    .top_avail(top_avail), .left_avail(left_avail),
    .org_valid(org_valid), .org_ready(org_ready), .org_row(org_row),
    .res_valid(res_valid), .res_ready(res_ready),
    .vres_row(vres_row), .hres_row(hres_row), .dcres_row(dcres_row),
    .res_rownum(res_rownum), .res_last(res_last),
    .v_ok(v_ok), .h_ok(h_ok), .dc_val(dc_val), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] res9(input int o, input int p);
    int d;
    d = o - p;
`ifdef INTRA16_RES_CLIP_EN
    if (d > 127) d = 127;
    if (d < -128) d = -128;
`endif
    return RW'(d);
  endfunction

  task automatic start_mb(input bit ta, input bit la);
    int st, sl;
    st = 0;
    sl = 0;
    for (int c = 0; c < 16; c++) begin
      st += m_top[c];
      sl += m_left[c];
    end
    if (ta && la)  m_dc = (st + sl + 16) / 32;
    else if (ta)   m_dc = (st + 8) / 16;
    else if (la)   m_dc = (sl + 8) / 16;
    else           m_dc = 128;
    m_v = ta;
    m_h = la;
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      top_pix[c*PW +: PW]  = PW'(m_top[c]);
      left_pix[c*PW +: PW] = PW'(m_left[c]);
    end
    top_avail  = ta;
    left_avail = la;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_rows(input int bp_row, input int bp_len, input int abort_row,
                          input bit mid_start);
    int   sent, got, cyc, bp_left;
    exp_t e;
    sent = 0; got = 0; cyc = 0; bp_left = bp_len;
    while (got < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (res_valid && got == bp_row && bp_left > 0) begin
        res_ready = 1'b0;
        bp_left--;
      end else begin
        res_ready = 1'b1;
      end
      if (sent < 16) begin
        org_valid = 1'b1;
        for (int c = 0; c < 16; c++) org_row[c*PW +: PW] = PW'(org_tb[sent][c]);
      end else begin
        org_valid = 1'b0;
      end
      start = mid_start && (sent == 4);
      if (start) top_pix = ~top_pix;
      #1;
      if (abort_row >= 0 && got == abort_row) begin
        reset = 1'b1;
        #1;
        total++;
        if ({res_valid, res_last, v_ok, h_ok, busy, done, org_ready, res_rownum, dc_val} !== 19'd0) begin
          bad++;
          $display("FAIL abort_ctrl got=%h exp=0",
                   {res_valid, res_last, v_ok, h_ok, busy, done, org_ready, res_rownum, dc_val});
        end
        total++;
        if ({vres_row, hres_row, dcres_row} !== {(48*RW){1'b0}}) begin
          bad++;
          $display("FAIL abort_data got=%h exp=0", {vres_row, hres_row, dcres_row});
        end
        @(negedge clk);
        reset     = 1'b0;
        org_valid = 1'b0;
        start     = 1'b0;
        sb_q.delete();
        return;
      end
      if (res_valid) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty got=row%0d exp=no_output", res_rownum);
        end else begin
          e = sb_q[0];
          total++;
          if (vres_row !== e.v) begin
            bad++; $display("FAIL vres row=%0d got=%h exp=%h", e.num, vres_row, e.v);
          end
          total++;
          if (hres_row !== e.h) begin
            bad++; $display("FAIL hres row=%0d got=%h exp=%h", e.num, hres_row, e.h);
          end
          total++;
          if (dcres_row !== e.d) begin
            bad++; $display("FAIL dcres row=%0d got=%h exp=%h", e.num, dcres_row, e.d);
          end
          total++;
          if ({res_rownum, res_last} !== {e.num, e.last}) begin
            bad++; $display("FAIL rownum_last got=%0d/%0d exp=%0d/%0d", res_rownum, res_last, e.num, e.last);
          end
          if (!res_ready || sent == 16) begin
            total++;
            if (org_ready !== 1'b0) begin
              bad++; $display("FAIL org_ready_held row=%0d got=%b exp=0", e.num, org_ready);
            end
          end
          if (res_ready) begin
            void'(sb_q.pop_front());
            got++;
          end
        end
      end
      if (org_valid && org_ready) begin
        e.num  = 4'(sent);
        e.last = (sent == 15);
        for (int c = 0; c < 16; c++) begin
          e.v[c*RW +: RW] = res9(org_tb[sent][c], m_top[c]);
          e.h[c*RW +: RW] = res9(org_tb[sent][c], m_left[sent]);
          e.d[c*RW +: RW] = res9(org_tb[sent][c], m_dc);
        end
        sb_q.push_back(e);
        sent++;
      end
    end
    org_valid = 1'b0;
    start     = 1'b0;
    total++;
    if (got != 16) begin
      bad++; $display("FAIL timeout got=%0d rows exp=16", got);
    end
    @(negedge clk);
    total++;
    if ({done, busy, res_valid} !== 3'b100) begin
      bad++; $display("FAIL done_pulse got=%b exp=100", {done, busy, res_valid});
    end
    total++;
    if ({v_ok, h_ok, dc_val} !== {m_v, m_h, PW'(m_dc)}) begin
      bad++; $display("FAIL mode_flags got=%b%b/%0d exp=%b%b/%0d", v_ok, h_ok, dc_val, m_v, m_h, m_dc);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; org_valid = 1'b0; res_ready = 1'b1;
    top_pix = '0; left_pix = '0; org_row = '0; top_avail = 1'b0; left_avail = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({res_valid, res_last, v_ok, h_ok, busy, done, org_ready, res_rownum, dc_val} !== 19'd0) begin
      bad++;
      $display("FAIL reset_ctrl got=%h exp=0",
               {res_valid, res_last, v_ok, h_ok, busy, done, org_ready, res_rownum, dc_val});
    end
    total++;
    if ({vres_row, hres_row, dcres_row} !== {(48*RW){1'b0}}) begin
      bad++; $display("FAIL reset_data got=%h exp=0", {vres_row, hres_row, dcres_row});
    end
    reset = 1'b0;
  endtask

  task automatic test_both_avail;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = 100; m_left[i] = 50;
      for (int c = 0; c < 16; c++) org_tb[i][c] = 80;
    end
    start_mb(1'b1, 1'b1);
    #1;
    total++;
    if ({org_ready, busy} !== 2'b01) begin
      bad++; $display("FAIL lat_sum got=%b exp=01", {org_ready, busy});
    end
    @(negedge clk);
    total++;
    if (org_ready !== 1'b0) begin
      bad++; $display("FAIL lat_div got=%b exp=0", org_ready);
    end
    @(negedge clk);
    total++;
    if ({org_ready, dc_val} !== {1'b1, 8'd75}) begin
      bad++; $display("FAIL lat_stream got=%b/%0d exp=1/75", org_ready, dc_val);
    end
    run_rows(-1, 0, -1, 1'b0);
  endtask

  task automatic test_neither;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = 200; m_left[i] = 30 + i;
      for (int c = 0; c < 16; c++) org_tb[i][c] = 0;
    end
    start_mb(1'b0, 1'b0);
    run_rows(-1, 0, -1, 1'b0);
  endtask

  task automatic test_top_only;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = i; m_left[i] = 77;
      for (int c = 0; c < 16; c++) org_tb[i][c] = i;
    end
    start_mb(1'b1, 1'b0);
    run_rows(-1, 0, -1, 1'b0);
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = $urandom_range(0, 255); m_left[i] = $urandom_range(0, 255);
      for (int c = 0; c < 16; c++) org_tb[i][c] = $urandom_range(0, 255);
    end
    start_mb(1'b0, 1'b1);
    run_rows(5, 3, -1, 1'b1);
  endtask

  task automatic test_clip;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = 255; m_left[i] = 0;
      for (int c = 0; c < 16; c++) org_tb[i][c] = 0;
    end
    start_mb(1'b1, 1'b1);
    run_rows(-1, 0, -1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      m_top[i] = 0; m_left[i] = 0;
      for (int c = 0; c < 16; c++) org_tb[i][c] = 255;
    end
    start_mb(1'b1, 1'b1);
    run_rows(-1, 0, -1, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 16; i++) begin
      m_top[i] = $urandom_range(0, 255); m_left[i] = $urandom_range(0, 255);
      for (int c = 0; c < 16; c++) org_tb[i][c] = $urandom_range(0, 255);
    end
    start_mb(1'b1, 1'b1);
    run_rows(-1, 0, 8, 1'b0);
    for (int i = 0; i < 16; i++) begin
      m_top[i] = $urandom_range(0, 255); m_left[i] = $urandom_range(0, 255);
      for (int c = 0; c < 16; c++) org_tb[i][c] = $urandom_range(0, 255);
    end
    start_mb(1'b1, 1'b1);
    run_rows(-1, 0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_both_avail();
    test_neither();
    test_top_only();
    test_backpressure();
    test_clip();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intra16_resgen.md
Name: intra16_resgen

Overview:
Upstream feeder for the 16x16 luma intra SAD stage. Captures the 16 top and 16 left reconstructed neighbours of a macroblock and computes the DC predictor. It then streams the 16 original rows and emits, one row per handshake, the signed residual rows for the Vertical, Horizontal and DC 16x16 prediction modes. Outputs are packed so the SAD stage can accumulate them directly.

Parameters:
PIX_W, 8, pixel bit width. Residual width RES_W = PIX_W+1 is a derived localparam, not overridable.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a macroblock; honoured only in IDLE
top_pix  in  16*PIX_W  top neighbours; pixel c at [c*PIX_W +: PIX_W]; sampled on accepted start
left_pix  in  16*PIX_W  left neighbours; pixel r = row r; sampled on accepted start
top_avail  in  1  top neighbours valid; sampled on accepted start
left_avail  in  1  left neighbours valid; sampled on accepted start
org_valid  in  1  org_row holds a valid original row
org_ready  out  1  block accepts org_row this cycle
org_row  in  16*PIX_W  one original row, pixel c at [c*PIX_W +: PIX_W]
res_valid  out  1  residual outputs valid
res_ready  in  1  downstream accepts residual row
vres_row  out  16*RES_W  signed residuals org - top[c]
hres_row  out  16*RES_W  signed residuals org - left[r]
dcres_row  out  16*RES_W  signed residuals org - dc
res_rownum  out  4  row index of current residual row
res_last  out  1  high with res_valid on row 15
v_ok  out  1  registered top_avail (Vertical mode legal)
h_ok  out  1  registered left_avail (Horizontal mode legal)
dc_val  out  PIX_W  computed DC predictor
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the row-15 residual is accepted

Behaviour:
- Reset (async): state IDLE. All outputs 0. Residual registers, row counter, neighbour registers and dc_val cleared.
- FSM states: IDLE, SUM, DIV, STREAM, DRAIN.
- IDLE: start=1 latches neighbours and avail flags into v_ok/h_ok, then moves to SUM. start outside IDLE is ignored, with no side effects.
- SUM (1 cycle): registers sumT = sum of top (PIX_W+4 bits) and sumL = sum of left. Goes to DIV.
- DIV (1 cycle): computes dc_val. Both available: (sumT+sumL+16)>>5. Top only: (sumT+8)>>4. Left only: (sumL+8)>>4. Neither: 1<<(PIX_W-1). Goes to STREAM. Latency from start to first org_ready: 3 cycles.
- STREAM: org_ready = !res_valid || res_ready. A row is accepted when org_valid && org_ready; its residuals are registered, res_valid rises the next cycle, and res_rownum equals the accept count. Residual per pixel is zero-extended org minus zero-extended predictor in RES_W two's complement. The residual for row r uses left[r]. On the row-15 accept, go to DRAIN.
- Unavailable modes: vres/hres are still computed from the latched (possibly stale) neighbours. Consumers gate on v_ok/h_ok.
- Output hold: residual outputs stay stable while res_valid && !res_ready. res_valid drops after acceptance if no new row was accepted in the same cycle.
- Simultaneous accept/issue: a new row accepted in the same cycle the current one is consumed keeps res_valid high. Full throughput is 1 row per cycle.
- DRAIN: org_ready=0. When row 15 is accepted, done pulses and the state returns to IDLE. start in that same cycle is ignored.
- v_ok, h_ok and dc_val hold until the next accepted start.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. A partial macroblock is discarded.

Optional Feature:
INTRA16_RES_CLIP_EN
- Defined: each residual saturates to [-(1<<(PIX_W-1)), (1<<(PIX_W-1))-1], sign-extended into RES_W. This is for SAD stages with PIX_W-wide inputs. Adds no latency.
- Undefined: full-range residuals, -(2^PIX_W - 1) to 2^PIX_W - 1.

Test Plan:
- Both available, top all 100, left all 50, org all 80, res_ready=1 -> dc_val=75; every row vres=-20, hres=+30, dcres=+5; res_rownum 0..15; res_last on row 15; done 1 cycle later.
- Neither available, org all 0 -> dc_val=128, v_ok=h_ok=0, dcres=-128 on all 256 pixels.
- Top only, top[c]=c (0..15), org row r all r -> dc_val=8; row 3 vres[c]=3-c; dcres=-5.
- Backpressure: res_ready low for 3 cycles at row 5 -> org_ready=0, outputs frozen at row 5, no row lost or duplicated, 16 rows total.
- Clip: top all 255, org all 0 -> vres=-255 without macro, -128 with INTRA16_RES_CLIP_EN. Left all 0, org 255 -> hres=255 vs 127.
- Reset asserted at row 8 -> all outputs 0 immediately. The next start runs a full 16-row block correctly. start during STREAM has no effect.
